// File: rtl/muldiv_ctrl_pkg.sv
// Shared types for the execute-stage HI/LO unit: operation codes, controller
// states, datapath widths and the conditional two's-complement helper.
package muldiv_ctrl_pkg;

  localparam int DIV_W = 32;

  typedef logic [31:0] i32;
  typedef logic [63:0] i64;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } muldiv_op_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_FIX   = 3'd3,
    ST_MUL   = 3'd4,
    ST_ZERO  = 3'd5,
    ST_DRAIN = 3'd6
  } state_t;

  // Two's-complement negate when n is set; |0x80000000| stays 0x80000000.
  function automatic i32 neg_if(input logic n, input i32 v);
    return n ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_divider.sv
// Iterative restoring unsigned divider, one quotient bit per cycle.
// done is high whenever no division is in progress; c = {rem, quo}.
module muldiv_ctrl_divider
  import muldiv_ctrl_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic valid,
  input  i32   a,
  input  i32   b,
  output logic done,
  output i64   c
);

  i32           rem_r;
  i32           quo_r;
  logic [5:0]   cnt_r;
  logic [DIV_W:0] sh_s;
  logic [DIV_W:0] diff_s;

  // b is read every iteration, so the caller must hold it stable.
  assign sh_s   = {rem_r, quo_r[DIV_W-1]};
  assign diff_s = sh_s - {1'b0, b};

  // Iteration register: load on valid, then shift/subtract until count hits 0.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rem_r <= 32'd0;
      quo_r <= 32'd0;
      cnt_r <= 6'd0;
    end else if (valid) begin
      rem_r <= 32'd0;
      quo_r <= a;
      cnt_r <= 6'(DIV_W);
    end else if (cnt_r != 6'd0) begin
      if (!diff_s[DIV_W]) begin
        rem_r <= diff_s[DIV_W-1:0];
        quo_r <= {quo_r[DIV_W-2:0], 1'b1};
      end else begin
        rem_r <= sh_s[DIV_W-1:0];
        quo_r <= {quo_r[DIV_W-2:0], 1'b0};
      end
      cnt_r <= cnt_r - 6'd1;
    end
  end

  assign done = (cnt_r == 6'd0);
  assign c    = {rem_r, quo_r};

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO unit controller: owns HI/LO, runs the registered multiplier inline and
// sequences the iterative divider with sign fix-up, b==0 bypass and flush drain.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  muldiv_op_t op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic       flush,
  output logic       ready,
  output logic       busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_t     state_r, state_s;
  i32         ua_r, ub_r, ua_s, ub_s;
  logic       qneg_r, rneg_r, qneg_s, rneg_s;
  i64         prod_r, prod_s;
  logic [2:0] mcnt_r, mcnt_s;
  logic       hi_we_s, lo_we_s, lat_we_s, prod_we_s;
  i32         hi_nx_s, lo_nx_s;
  logic       div_valid_s, div_done_s;
  i64         div_c_s;
  logic       mul_sgn_s;
  i64         mul_a_s, mul_b_s;

  muldiv_ctrl_divider u_divider (
    .clk    (clk),
    .resetn (~reset),
    .valid  (div_valid_s),
    .a      (ua_r),
    .b      (ub_r),
    .done   (div_done_s),
    .c      (div_c_s)
  );

  assign mul_sgn_s = (op == OP_MULT);
  assign mul_a_s   = {{32{mul_sgn_s & a[31]}}, a};
  assign mul_b_s   = {{32{mul_sgn_s & b[31]}}, b};
  assign prod_s    = mul_a_s * mul_b_s;

  assign div_valid_s = (state_r == ST_LOAD);
  assign ready       = (state_r == ST_IDLE);
  assign busy        = (start & ~ready) | (state_r != ST_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state, write enables and operand preparation.
  always_comb begin
    state_s   = state_r;
    hi_we_s   = 1'b0;
    lo_we_s   = 1'b0;
    hi_nx_s   = 32'd0;
    lo_nx_s   = 32'd0;
    lat_we_s  = 1'b0;
    prod_we_s = 1'b0;
    mcnt_s    = mcnt_r;
    ua_s      = 32'd0;
    ub_s      = 32'd0;
    qneg_s    = 1'b0;
    rneg_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start && !flush) begin
          case (op)
            OP_MTHI: begin
              hi_we_s = 1'b1;
              hi_nx_s = a;
            end
            OP_MTLO: begin
              lo_we_s = 1'b1;
              lo_nx_s = a;
            end
            OP_MULT, OP_MULTU: begin
              prod_we_s = 1'b1;
              mcnt_s    = 3'd0;
              state_s   = ST_MUL;
            end
            OP_DIV, OP_DIVU: begin
              lat_we_s = 1'b1;
              if (b == 32'd0) begin
                ua_s    = a;
                state_s = ST_ZERO;
              end else begin
                qneg_s  = (op == OP_DIV) & (a[31] ^ b[31]);
                rneg_s  = (op == OP_DIV) & a[31];
                ua_s    = neg_if((op == OP_DIV) & a[31], a);
                ub_s    = neg_if((op == OP_DIV) & b[31], b);
                state_s = ST_LOAD;
              end
            end
            default: begin
              state_s = ST_IDLE;
            end
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_s = flush ? ST_DRAIN : ST_RUN;
      end
      ST_RUN: begin
        if (flush) begin
          state_s = ST_DRAIN;
        end else if (div_done_s) begin
          state_s = ST_FIX;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_FIX: begin
        state_s = ST_IDLE;
        if (!flush) begin
          hi_we_s = 1'b1;
          lo_we_s = 1'b1;
          hi_nx_s = neg_if(rneg_r, div_c_s[63:32]);
          lo_nx_s = neg_if(qneg_r, div_c_s[31:0]);
        end else begin
          hi_we_s = 1'b0;
        end
      end
      ST_MUL: begin
        if (flush) begin
          state_s = ST_IDLE;
        end else if (mcnt_r == 3'(MUL_LAT - 1)) begin
          hi_we_s = 1'b1;
          lo_we_s = 1'b1;
          hi_nx_s = prod_r[63:32];
          lo_nx_s = prod_r[31:0];
          state_s = ST_IDLE;
        end else begin
          mcnt_s = mcnt_r + 3'd1;
        end
      end
      ST_ZERO: begin
        state_s = ST_IDLE;
        if (!flush) begin
          hi_we_s = 1'b1;
          lo_we_s = 1'b1;
          hi_nx_s = ua_r;
          lo_nx_s = 32'hFFFF_FFFF;
        end else begin
          hi_we_s = 1'b0;
        end
      end
      ST_DRAIN: begin
        state_s = div_done_s ? ST_IDLE : ST_DRAIN;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // HI/LO and operand registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi     <= 32'd0;
      lo     <= 32'd0;
      ua_r   <= 32'd0;
      ub_r   <= 32'd0;
      qneg_r <= 1'b0;
      rneg_r <= 1'b0;
      prod_r <= 64'd0;
      mcnt_r <= 3'd0;
    end else begin
      if (hi_we_s) hi <= hi_nx_s;
      if (lo_we_s) lo <= lo_nx_s;
      if (lat_we_s) begin
        ua_r   <= ua_s;
        ub_r   <= ub_s;
        qneg_r <= qneg_s;
        rneg_r <= rneg_s;
      end
      if (prod_we_s) prod_r <= prod_s;
      mcnt_r <= mcnt_s;
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: vector table through a HI/LO scoreboard,
// plus hand sequences for flush+start, flush drain and reset mid-divide.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  localparam int MUL_LAT = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  muldiv_op_t op = OP_NOP;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic       flush = 1'b0;
  logic       ready, busy;
  logic [31:0] hi, lo;

  int total = 0;
  int bad = 0;

  typedef struct {
    muldiv_op_t op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
    int          ecyc;
    int          edv;
  } vec_t;

  typedef struct {
    logic [31:0] h;
    logic [31:0] l;
  } exp_t;

  exp_t sb[$];
  vec_t vt[12];

  muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .ready(ready), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input int idx, input muldiv_op_t op_i, input logic [31:0] a_i,
                        input logic [31:0] b_i, input logic [31:0] eh, input logic [31:0] el,
                        input int ecyc, input int edv);
    int nready, wr, dv;
    logic busy_ok;
    logic [31:0] ph, pl;
    exp_t e;
    sb.push_back('{eh, el});
    @(negedge clk);
    start = 1'b1; op = op_i; a = a_i; b = b_i;
    ph = hi; pl = lo; nready = 0; wr = 0; dv = 0; busy_ok = 1'b1;
    @(negedge clk);
    start = 1'b0; op = OP_NOP;
    while (!ready && nready < 200) begin
      if (!busy) busy_ok = 1'b0;
      if (dut.div_valid_s) dv++;
      if (hi !== ph || lo !== pl) wr++;
      ph = hi; pl = lo;
      nready++;
      @(negedge clk);
    end
    if (hi !== ph || lo !== pl) wr++;
    chk($sformatf("v%0d timeout", idx), 64'(nready < 200), 64'd1);
    e = sb.pop_front();
    chk($sformatf("v%0d hi", idx), 64'(hi), 64'(e.h));
    chk($sformatf("v%0d lo", idx), 64'(lo), 64'(e.l));
    chk($sformatf("v%0d busy", idx), 64'(busy_ok), 64'd1);
    chk($sformatf("v%0d writes<=1", idx), 64'(wr <= 1), 64'd1);
    if (ecyc > 0) chk($sformatf("v%0d cycles", idx), 64'(nready + 1), 64'(ecyc));
    if (edv >= 0) chk($sformatf("v%0d div_valid", idx), 64'(dv), 64'(edv));
  endtask

  initial begin
    int n;
    vt[0]  = '{OP_DIVU,  32'd100,        32'd7,          32'd2,          32'd14,         0, 1};
    vt[1]  = '{OP_DIV,   32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD,  0, 1};
    vt[2]  = '{OP_DIV,   32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          32'h8000_0000,  0, 1};
    vt[3]  = '{OP_MULT,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  32'hFFFF_FFFA,  1 + MUL_LAT, 0};
    vt[4]  = '{OP_MULTU, 32'hFFFF_FFFE,  32'd3,          32'h0000_0002,  32'hFFFF_FFFA,  1 + MUL_LAT, 0};
    vt[5]  = '{OP_DIVU,  32'h0000_1234,  32'd0,          32'h0000_1234,  32'hFFFF_FFFF,  2, 0};
    vt[6]  = '{OP_DIV,   32'd7,          32'hFFFF_FFFE,  32'd1,          32'hFFFF_FFFD,  0, 1};
    vt[7]  = '{OP_MTLO,  32'hDEAD_BEEF,  32'd0,          32'd1,          32'hDEAD_BEEF,  1, 0};
    vt[8]  = '{OP_MTHI,  32'h0BAD_F00D,  32'd0,          32'h0BAD_F00D,  32'hDEAD_BEEF,  1, 0};
    vt[9]  = '{OP_DIVU,  32'hFFFF_FFFF,  32'd1,          32'h0,          32'hFFFF_FFFF,  0, 1};
    vt[10] = '{OP_DIV,   32'h8000_0000,  32'd0,          32'h8000_0000,  32'hFFFF_FFFF,  2, 0};
    vt[11] = '{OP_MULT,  32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  32'h0,          1 + MUL_LAT, 0};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset ready", 64'(ready), 64'd1);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);

    for (int i = 0; i < 12; i++)
      run_op(i, vt[i].op, vt[i].a, vt[i].b, vt[i].eh, vt[i].el, vt[i].ecyc, vt[i].edv);

    // start with flush in IDLE is dropped
    @(negedge clk);
    start = 1'b1; op = OP_MTHI; a = 32'h5555; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; op = OP_NOP; flush = 1'b0;
    chk("flush+start hi", 64'(hi), 64'h4000_0000);
    chk("flush+start ready", 64'(ready), 64'd1);

    run_op(20, OP_MTHI, 32'hAAAA, 32'd0, 32'hAAAA, 32'h0, 1, 0);

    // flush five cycles into RUN, then drain until the divider finishes
    @(negedge clk);
    start = 1'b1; op = OP_DIV; a = 32'd10; b = 32'd3;
    @(negedge clk);
    start = 1'b0; op = OP_NOP;
    repeat (5) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("drain ready", 64'(ready), 64'd0);
    chk("drain busy", 64'(busy), 64'd1);
    n = 0;
    while (!ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("drain waits divider", 64'(n >= 20 && n < 200), 64'd1);
    chk("drain hi", 64'(hi), 64'hAAAA);
    chk("drain lo", 64'(lo), 64'h0);

    run_op(21, OP_DIVU, 32'd9, 32'd4, 32'd1, 32'd2, 0, 1);

    // reset in the middle of RUN
    @(negedge clk);
    start = 1'b1; op = OP_DIV; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0; op = OP_NOP;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrun reset ready", 64'(ready), 64'd1);
    chk("midrun reset hi", 64'(hi), 64'd0);
    chk("midrun reset lo", 64'(lo), 64'd0);

    run_op(22, OP_DIVU, 32'd1, 32'd1, 32'd0, 32'd1, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Execute-stage HI/LO unit controller for the MIPS core.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the execute stage.
- Owns the HI/LO registers and stalls the pipeline while an operation is in flight.
- Sequences one instance of the iterative unsigned divider: operand latching, sign handling, result fix-up and divide-by-zero bypass.
- Handles pipeline flush even though the divider has no abort input.

Parameters:
MUL_LAT, 1, number of cycles the registered 64-bit product is held in state MUL before writeback (1..4).

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  request valid; accepted only when ready=1
op  in  3  muldiv_op_t: NOP, MULT, MULTU, DIV, DIVU, MTHI, MTLO
a  in  32  rs operand
b  in  32  rt operand
flush  in  1  kill in-flight op; no HI/LO update
ready  out  1  controller in IDLE and can accept start
busy  out  1  stall request to the pipeline; equals start&~ready, or state!=IDLE
hi  out  32  architectural HI
lo  out  32  architectural LO

Behaviour:
- Reset: state=IDLE, hi=0, lo=0, all internal operand and sign registers 0. Divider resetn is driven by ~reset.
- MTHI/MTLO in IDLE: hi (or lo) written at the next edge. Stays in IDLE, 1-cycle, never busy.
- MULT/MULTU in IDLE:
  - Product registered: signed or unsigned 32x32 gives 64 bits.
  - Go to MUL, hold MUL_LAT cycles, then write {hi,lo}=product and return to IDLE.
- DIV/DIVU in IDLE, b!=0:
  - Latch ua=|a|, ub=|b| for DIV (raw values for DIVU); latch qneg=a[31]^b[31] and rneg=a[31] for DIV (both 0 for DIVU).
  - IDLE -> LOAD -> RUN -> FIX -> IDLE.
  - LOAD: div_valid=1 for exactly this cycle, with div_a=ua and div_b=ub.
  - RUN: div_valid=0. div_a and div_b must stay stable because the divider reads b every iteration.
  - div_done is ignored in LOAD, since it is high while the divider is idle. It is sampled only in RUN.
  - In RUN, when div_done=1, go to FIX. div_c={rem,quo} is valid during FIX, the cycle after done.
  - FIX: lo = qneg ? -quo : quo; hi = rneg ? -rem : rem; written at the FIX edge.
- DIV/DIVU with b==0: bypass the divider. IDLE -> ZERO -> IDLE; ZERO writes hi=a, lo=32'hFFFF_FFFF.
- Signed edge case: DIV 0x80000000/0xFFFFFFFF uses |a|=0x80000000 as unsigned. Result is lo=0x80000000, hi=0, with no exception.
- Flush:
  - In MUL, ZERO or FIX: return to IDLE, no write.
  - In LOAD or RUN: go to DRAIN. DRAIN waits for div_done (sampled from the cycle after LOAD), then goes to IDLE with no write. ready stays 0 in DRAIN.
  - flush together with start in IDLE: start is ignored.
- Simultaneous start and completion: not possible, because start is accepted only in IDLE.
- Reset mid-operation: everything returns to IDLE at the next edge, including the divider.
- Latency: MUL = 1+MUL_LAT cycles; DIV = divider cycles + 2; ZERO = 2 cycles.

Decomposition:
- Shared package: muldiv_op_t enum; state enum (IDLE, LOAD, RUN, FIX, MUL, ZERO, DRAIN); DIV_W=32 constant; i32/i64 typedefs (existing).
- One sub-module: divider, instantiated as-is. The multiplier stays inline as a registered '*' expression.

Test Plan:
- DIVU a=100, b=7 -> after completion lo=14, hi=2; busy high throughout; single HI/LO write.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MULT a=0xFFFFFFFE, b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA. Completion after 1+MUL_LAT cycles.
- DIVU b=0, a=0x1234 -> ZERO path, 2 cycles, hi=0x1234, lo=0xFFFFFFFF; div_valid never asserted.
- MTHI 0xAAAA then DIV 10/3, flush asserted 5 cycles into RUN -> DRAIN until div_done, then ready=1; hi stays 0xAAAA and lo is unchanged. The next DIVU 9/4 gives lo=2, hi=1.
- Reset asserted mid-RUN -> next cycle ready=1, hi=lo=0. A following DIVU 1/1 gives lo=1, hi=0.
